alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue stage for the RISC-V pipeline: decodes one instruction into the ALU
//  opcode and operands, and registers them for the execute stage.
//  It is the producer side of the ALU interface and drives Control_Line, SrcA and SrcB.
//  Upstream (decode/regfile) and downstream (EX) use a valid/ready handshake.
//  Latency is one cycle. A flush input kills the held instruction on branch redirect.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  FLUSH_IN  1   1: flush also drops a same-cycle incoming beat; 0: flush kills held entry only
// PORTS
//  clk           in   1     rising-edge clock, the only clock
//  reset         in   1     synchronous, active-high reset
//  in_valid      in   1     upstream beat valid
//  in_ready      out  1     stage can accept a beat this cycle
//  instr         in   32    raw instruction word
//  rs1_data      in   32    register-file read port 1
//  rs2_data      in   32    register-file read port 2
//  flush         in   1     kill the held entry (branch taken / redirect)
//  out_valid     out  1     registered beat valid toward EX
//  out_ready     in   1     EX consumes the beat this cycle
//  Control_Line  out  3     ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
//  SrcA          out  32    ALU operand A
//  SrcB          out  32    ALU operand B (register or sign-extended immediate)
//  rd            out  5     destination register
//  reg_write     out  1     writeback enable
//  mem_op        out  2     00 none, 01 load, 10 store
//  store_data    out  32    rs2_data captured for stores
//  illegal       out  1     unsupported encoding; remaining outputs are safe-zeroed
// BEHAVIOUR
//  Reset: all outputs registered to 0. in_ready is 1 the cycle after reset deasserts.
//  Handshake:
//   - in_ready = !out_valid | out_ready (combinational; single entry, no skid).
//   - load = in_valid & in_ready. On load, all decoded outputs update at the next edge.
//   - out_valid is held with all outputs stable until out_ready. Nothing may change while stalled.
//   - out_ready with no load: out_valid goes to 0 next cycle. Data regs may hold stale values.
//  Flush:
//   - Forces out_valid=0 at the next edge and has priority over the held entry.
//   - With FLUSH_IN=1, a same-cycle load is also discarded.
//   - With FLUSH_IN=0, a same-cycle load is captured and out_valid=1.
//  Reset has priority over flush and load. A reset mid-stall drops the entry.
//  Decode (opcode = instr[6:0], f3 = instr[14:12], f7b = instr[30]):
//   - 0110011 R-type, SrcB = rs2_data:
//     - f3 000: ADD (f7b=0) or SUB (f7b=1).
//     - f3 111 AND, 110 OR, 010 SLT, 100 XOR.
//   - 0010011 I-type: same f3 map with ADD only (f7b ignored). SrcB = sext(instr[31:20]).
//   - 0000011 load: ADD, SrcB = sext(instr[31:20]), mem_op = 01, reg_write = 1.
//   - 0100011 store: ADD, SrcB = sext({instr[31:25], instr[11:7]}), mem_op = 10, reg_write = 0.
//   - 1100011 branch: SUB, SrcB = rs2_data, reg_write = 0. EX uses zero.
//   - SrcA = rs1_data for every legal op.
//   - Any other opcode or f3 (e.g. shifts, LUI, JAL): illegal=1, Control_Line=000,
//     SrcA=SrcB=0, reg_write=0, mem_op=00. The beat still handshakes normally.
//  reg_write is forced to 0 when rd == 0. rd = instr[11:7] for all ops.
//  Immediates are sign-extended from bit 31 to XLEN. No arithmetic is done in this stage.
// TESTING
//  T1: Reset held 3 cycles -> out_valid=0, all outputs 0; in_ready=1 after release.
//  T2: add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1
//      -> next cycle Control_Line=000, SrcA=5, SrcB=7, rd=3, reg_write=1.
//  T3: sub (0x402081B3) -> Control_Line=001.
//      addi x5,x0,-1 (0xFFF00293) -> SrcB=0xFFFFFFFF, reg_write=1.
//  T4: sw x2,8(x1) (0x0020A423), rs2=0xDEAD
//      -> Control_Line=000, SrcB=8, mem_op=10, store_data=0xDEAD, reg_write=0.
//  T5: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and outputs stable;
//      out_ready=1 -> next beat loads with no loss or duplication.
//  T6: Flush while stalled with in_valid=1 -> out_valid=0 next cycle (FLUSH_IN=1).
//      Opcode 0x37 (LUI) -> illegal=1, reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream decode/regfile beat in, decoded ALU beat out to EX.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Upstream beat
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;

    // Downstream beat toward EX
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      Control_Line;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [4:0]      rd;
    logic            reg_write;
    logic [1:0]      mem_op;
    logic [XLEN-1:0] store_data;
    logic            illegal;

    // Issue stage side
    modport master (
        input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, Control_Line, SrcA, SrcB, rd,
               reg_write, mem_op, store_data, illegal
    );

    // Environment side (decode/regfile + EX)
    modport slave (
        output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, Control_Line, SrcA, SrcB, rd,
               reg_write, mem_op, store_data, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes one instruction into ALU op/operands and registers
// it as a single-entry valid/ready pipeline slot toward EX.
module alu_issue_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FLUSH_IN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.master  bus
);
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned EXT_W  = XLEN - IMM_W;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            f7b;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic            unused_instr_bits;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign f7b    = bus.instr[30];
    assign rd_idx = bus.instr[11:7];
    assign imm_i  = {{EXT_W{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{EXT_W{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    // rs1 index field is resolved upstream by the register file
    assign unused_instr_bits = ^bus.instr[19:15];

    // Decoded beat, valid only when a load happens
    logic [2:0]      dec_ctrl;
    logic [XLEN-1:0] dec_srca;
    logic [XLEN-1:0] dec_srcb;
    logic            dec_reg_write;
    logic [1:0]      dec_mem_op;
    logic [XLEN-1:0] dec_store_data;
    logic            dec_illegal;
    logic [2:0]      f3_ctrl;
    logic            f3_ok;

    // Register/immediate f3 function map shared by R- and I-type
    always_comb begin
        f3_ctrl = ALU_ADD;
        f3_ok   = 1'b1;
        case (f3)
            3'b000:  f3_ctrl = (opcode == OP_R && f7b) ? ALU_SUB : ALU_ADD;
            3'b111:  f3_ctrl = ALU_AND;
            3'b110:  f3_ctrl = ALU_OR;
            3'b010:  f3_ctrl = ALU_SLT;
            3'b100:  f3_ctrl = ALU_XOR;
            default: f3_ok   = 1'b0;
        endcase
    end

    // Instruction decode into ALU op, operands and side-band controls
    always_comb begin
        dec_ctrl       = ALU_ADD;
        dec_srca       = bus.rs1_data;
        dec_srcb       = '0;
        dec_reg_write  = 1'b0;
        dec_mem_op     = MEM_NONE;
        dec_store_data = '0;
        dec_illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl      = f3_ctrl;
                dec_srcb      = bus.rs2_data;
                dec_reg_write = 1'b1;
                dec_illegal   = ~f3_ok;
            end
            OP_I: begin
                dec_ctrl      = f3_ctrl;
                dec_srcb      = imm_i;
                dec_reg_write = 1'b1;
                dec_illegal   = ~f3_ok;
            end
            OP_LOAD: begin
                dec_srcb      = imm_i;
                dec_reg_write = 1'b1;
                dec_mem_op    = MEM_LOAD;
            end
            OP_STORE: begin
                dec_srcb       = imm_s;
                dec_mem_op     = MEM_STORE;
                dec_store_data = bus.rs2_data;
            end
            OP_BRANCH: begin
                dec_ctrl = ALU_SUB;
                dec_srcb = bus.rs2_data;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Unsupported encodings go to EX as a harmless no-op
        if (dec_illegal) begin
            dec_ctrl       = ALU_ADD;
            dec_srca       = '0;
            dec_srcb       = '0;
            dec_reg_write  = 1'b0;
            dec_mem_op     = MEM_NONE;
            dec_store_data = '0;
        end
        if (rd_idx == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    logic            valid_q, valid_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] srca_q, srca_d;
    logic [XLEN-1:0] srcb_q, srcb_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic [1:0]      mem_op_q, mem_op_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic            illegal_q, illegal_d;
    logic            take;
    logic            capture;

    assign bus.in_ready = ~valid_q | bus.out_ready;
    assign take         = bus.in_valid & bus.in_ready;
    // With FLUSH_IN set, a redirect also kills the beat arriving this cycle
    assign capture      = take & ~(bus.flush & FLUSH_IN);

    // Slot next state: capture wins, otherwise flush or consume empties the slot
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_op_d     = mem_op_q;
        store_data_d = store_data_q;
        illegal_d    = illegal_q;
        if (capture) begin
            valid_d      = 1'b1;
            ctrl_d       = dec_ctrl;
            srca_d       = dec_srca;
            srcb_d       = dec_srcb;
            rd_d         = rd_idx;
            reg_write_d  = dec_reg_write;
            mem_op_d     = dec_mem_op;
            store_data_d = dec_store_data;
            illegal_d    = dec_illegal;
        end else if (bus.flush || bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_op_q     <= '0;
            store_data_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_op_q     <= mem_op_d;
            store_data_q <= store_data_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.Control_Line = ctrl_q;
    assign bus.SrcA         = srca_q;
    assign bus.SrcB         = srcb_q;
    assign bus.rd           = rd_q;
    assign bus.reg_write    = reg_write_q;
    assign bus.mem_op       = mem_op_q;
    assign bus.store_data   = store_data_q;
    assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: reference decode queued at load, compared at EX.
module tb_alu_issue_stage;
    localparam int unsigned XLEN     = 32;
    localparam bit          FLUSH_IN = 1'b1;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  mem;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   mdl_valid = 1'b0;
    exp_t sb_q[$];

    alu_issue_stage_if #(.XLEN(XLEN)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .FLUSH_IN(FLUSH_IN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  fn;
        logic [31:0] immi;
        logic [31:0] imms;
        bit          ok;
        op   = ins[6:0];
        fn   = ins[14:12];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        e    = '{ctrl: 3'd0, srca: 32'd0, srcb: 32'd0, rd: ins[11:7], rw: 1'b0, mem: 2'd0, sd: 32'd0, ill: 1'b0};
        ok   = 1'b1;
        if (op == 7'h33 || op == 7'h13) begin
            e.srca = a;
            e.srcb = (op == 7'h33) ? b : immi;
            e.rw   = 1'b1;
            if (fn == 3'b000)      e.ctrl = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
            else if (fn == 3'b111) e.ctrl = 3'd2;
            else if (fn == 3'b110) e.ctrl = 3'd3;
            else if (fn == 3'b010) e.ctrl = 3'd4;
            else if (fn == 3'b100) e.ctrl = 3'd5;
            else                   ok = 1'b0;
        end else if (op == 7'h03) begin
            e.srca = a; e.srcb = immi; e.mem = 2'd1; e.rw = 1'b1;
        end else if (op == 7'h23) begin
            e.srca = a; e.srcb = imms; e.mem = 2'd2; e.sd = b;
        end else if (op == 7'h63) begin
            e.srca = a; e.srcb = b; e.ctrl = 3'd1;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e = '{ctrl: 3'd0, srca: 32'd0, srcb: 32'd0, rd: ins[11:7], rw: 1'b0, mem: 2'd0, sd: 32'd0, ill: 1'b1};
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // One input cycle: drive just after the active edge, hold until the next one
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference slot model, advanced on each active edge
    initial begin
        bit rdy;
        bit ld;
        forever begin
            @(posedge clk);
            if (reset) begin
                mdl_valid = 1'b0;
                sb_q.delete();
            end else begin
                rdy = !mdl_valid || bus.out_ready;
                ld  = bus.in_valid && rdy;
                if (bus.flush) begin
                    sb_q.delete();
                    mdl_valid = 1'b0;
                    if (ld && !FLUSH_IN) begin
                        sb_q.push_back(ref_decode(bus.instr, bus.rs1_data, bus.rs2_data));
                        mdl_valid = 1'b1;
                    end
                end else begin
                    if (mdl_valid && bus.out_ready) begin
                        void'(sb_q.pop_front());
                        mdl_valid = 1'b0;
                    end
                    if (ld) begin
                        sb_q.push_back(ref_decode(bus.instr, bus.rs1_data, bus.rs2_data));
                        mdl_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor on the inactive edge; held beats are rechecked every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_eq("in_ready", 32'(bus.in_ready), 32'(!mdl_valid || bus.out_ready));
                check_eq("out_valid", 32'(bus.out_valid), 32'(mdl_valid));
                if (mdl_valid) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q[0];
                        check_eq("ctrl", 32'(bus.Control_Line), 32'(e.ctrl));
                        check_eq("srca", bus.SrcA, e.srca);
                        check_eq("srcb", bus.SrcB, e.srcb);
                        check_eq("rd", 32'(bus.rd), 32'(e.rd));
                        check_eq("reg_write", 32'(bus.reg_write), 32'(e.rw));
                        check_eq("mem_op", 32'(bus.mem_op), 32'(e.mem));
                        check_eq("store_data", bus.store_data, e.sd);
                        check_eq("illegal", 32'(bus.illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    localparam logic [6:0] RAND_OPS [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33};

    initial begin
        logic [31:0] ins;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;

        // Reset held three cycles: everything zero
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_ctrl", 32'(bus.Control_Line), 32'd0);
        check_eq("rst_srca", bus.SrcA, 32'd0);
        check_eq("rst_srcb", bus.SrcB, 32'd0);
        check_eq("rst_rd", 32'(bus.rd), 32'd0);
        check_eq("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check_eq("rst_mem_op", 32'(bus.mem_op), 32'd0);
        check_eq("rst_store_data", bus.store_data, 32'd0);
        check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed R/I/S beats
        cyc(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        cyc(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        cyc(1'b1, 32'hFFF00293, 32'd9, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020A423, 32'h100, 32'hDEAD, 1'b1, 1'b0);
        cyc(1'b1, 32'h00000033, 32'd1, 32'd2, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Stall four cycles with a waiting beat, then release
        cyc(1'b1, 32'h0020F1B3, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 32'h0020C233, 32'h1234, 32'h4321, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020C233, 32'h1234, 32'h4321, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush while stalled with a beat waiting
        cyc(1'b1, 32'h0020E2B3, 32'hAA, 32'h55, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020A333, 32'd3, 32'd4, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020A333, 32'd3, 32'd4, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // LUI, branch, load, shift
        cyc(1'b1, 32'h123452B7, 32'd8, 32'd9, 1'b1, 1'b0);
        cyc(1'b1, 32'hFE208EE3, 32'd8, 32'd9, 1'b1, 1'b0);
        cyc(1'b1, 32'hFFC0A383, 32'h2000, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'h00209393, 32'd8, 32'd9, 1'b1, 1'b0);

        // Reset mid-stall drops the held entry
        cyc(1'b1, 32'h002081B3, 32'd1, 32'd1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Randomised traffic with backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            ins      = $urandom;
            ins[6:0] = RAND_OPS[$urandom_range(0, 7)];
            cyc(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Drain and confirm nothing is left outstanding
        repeat (3) cyc(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
